// File: rtl/afe_ro_cfg_pkg.sv
// Shared definitions for the AFE readout configuration bus: default bus
// widths and the master state encoding, also used by the cfg slaves.
package afe_ro_cfg_pkg;

    localparam int unsigned CFG_ADDR_W_DEF = 11;
    localparam int unsigned CFG_DATA_W_DEF = 32;

    // State encoding, also visible to slaves as a typed enum
    typedef enum logic [1:0] {
        CFG_ST_IDLE   = 2'd0,
        CFG_ST_ACCESS = 2'd1,
        CFG_ST_RESP   = 2'd2
    } cfg_state_e;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/afe_ro_cfg_master.sv
// Configuration bus master: takes one request at a time, issues a single
// cfg access beat (held until the slave is ready or a timeout expires) and
// returns a response carrying read data or a timeout error.
module afe_ro_cfg_master
    import afe_ro_cfg_pkg::*;
#(
    parameter int unsigned ADDR_W         = CFG_ADDR_W_DEF,
    parameter int unsigned DATA_W         = CFG_DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_rwn_i,
    input  logic [DATA_W-1:0] req_wdata_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,

    output logic [ADDR_W-1:0] cfg_addr_o,
    output logic [DATA_W-1:0] cfg_data_o,
    output logic              cfg_valid_o,
    output logic              cfg_rwn_o,
    input  logic [DATA_W-1:0] cfg_data_i,
    input  logic              cfg_ready_i
);

    // Counter wide enough to hold TIMEOUT_CYCLES itself
    localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [ADDR_W-1:0] cfg_addr_q,  cfg_addr_d;
    logic [DATA_W-1:0] cfg_data_q,  cfg_data_d;
    logic              cfg_rwn_q,   cfg_rwn_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

    // Next-state and register-update decode for the IDLE/ACCESS/RESP sequence
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_data_d  = cfg_data_q;
        cfg_rwn_d   = cfg_rwn_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    cfg_addr_d = req_addr_i;
                    cfg_data_d = req_wdata_i;
                    cfg_rwn_d  = req_rwn_i;
                    cnt_d      = '0;
                    state_d    = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // Ready is tested first so a completion in the last
                // timeout cycle is still reported as a success.
                if (cfg_ready_i) begin
                    rsp_rdata_d = cfg_rwn_q ? cfg_data_i : '0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and captured bus/response registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            cfg_rwn_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            cfg_rwn_q   <= cfg_rwn_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Handshake outputs are pure state decode; data outputs come from registers
    always_comb begin
        req_ready_o = (state_q == ST_IDLE);
        cfg_valid_o = (state_q == ST_ACCESS);
        rsp_valid_o = (state_q == ST_RESP);
        cfg_addr_o  = cfg_addr_q;
        cfg_data_o  = cfg_data_q;
        cfg_rwn_o   = cfg_rwn_q;
        rsp_rdata_o = rsp_rdata_q;
        rsp_err_o   = rsp_err_q;
    end

endmodule

// File: tb/tb_afe_ro_cfg_master.sv
// Testbench for afe_ro_cfg_master: table of single transactions against a
// scripted slave, plus sequences for latency, response backpressure and
// reset in the middle of an access.
module tb_afe_ro_cfg_master;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int NEVER  = 255;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic              req_rwn_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;
    logic [ADDR_W-1:0] cfg_addr_o;
    logic [DATA_W-1:0] cfg_data_o;
    logic              cfg_valid_o;
    logic              cfg_rwn_o;
    logic [DATA_W-1:0] cfg_data_i;
    logic              cfg_ready_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    afe_ro_cfg_master #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_addr_i (req_addr_i),
        .req_rwn_i  (req_rwn_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o),
        .cfg_addr_o (cfg_addr_o),
        .cfg_data_o (cfg_data_o),
        .cfg_valid_o(cfg_valid_o),
        .cfg_rwn_o  (cfg_rwn_o),
        .cfg_data_i (cfg_data_i),
        .cfg_ready_i(cfg_ready_i)
    );

    typedef struct {
        logic              rwn;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] sdata;      // slave read data on its ready beat
        int                delay;      // non-ready beats before ready
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_err;
        int                exp_beats;  // cycles cfg_valid_o is high
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Runs one transaction from a negedge-aligned start; ends negedge-aligned in IDLE.
    task automatic run_txn(input int idx, input vec_t v);
        int beats;
        int guard;
        req_valid_i = 1'b1;
        req_addr_i  = v.addr;
        req_rwn_i   = v.rwn;
        req_wdata_i = v.wdata;
        chk($sformatf("v%0d_req_ready", idx), 64'(req_ready_o), 64'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
        beats = 0;
        guard = 0;
        while (!rsp_valid_o && guard < 40) begin
            if (cfg_valid_o) begin
                beats++;
                chk($sformatf("v%0d_b%0d_addr", idx, beats), 64'(cfg_addr_o), 64'(v.addr));
                chk($sformatf("v%0d_b%0d_rwn", idx, beats), 64'(cfg_rwn_o), 64'(v.rwn));
                chk($sformatf("v%0d_b%0d_data", idx, beats), 64'(cfg_data_o), 64'(v.wdata));
                cfg_ready_i = (beats == v.delay + 1);
                cfg_data_i  = cfg_ready_i ? v.sdata : 32'hDEAD_BEEF;
            end
            @(negedge clk);
            cfg_ready_i = 1'b0;
            cfg_data_i  = 32'hDEAD_BEEF;
            guard++;
        end
        chk($sformatf("v%0d_rsp_valid", idx), 64'(rsp_valid_o), 64'd1);
        chk($sformatf("v%0d_beats", idx), 64'(beats), 64'(v.exp_beats));
        chk($sformatf("v%0d_rdata", idx), 64'(rsp_rdata_o), 64'(v.exp_rdata));
        chk($sformatf("v%0d_err", idx), 64'(rsp_err_o), 64'(v.exp_err));
        chk($sformatf("v%0d_cfg_valid_resp", idx), 64'(cfg_valid_o), 64'd0);
        chk($sformatf("v%0d_req_ready_resp", idx), 64'(req_ready_o), 64'd0);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk($sformatf("v%0d_idle_req_ready", idx), 64'(req_ready_o), 64'd1);
        chk($sformatf("v%0d_idle_rsp_valid", idx), 64'(rsp_valid_o), 64'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_rwn_i   = 1'b0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b0;
        cfg_data_i  = 32'hDEAD_BEEF;
        cfg_ready_i = 1'b0;

        //            rwn   addr     wdata          sdata          delay  rdata          err  beats
        vecs[0] = '{1'b0, 11'h000, 32'h0000_0001, 32'h0000_0000, 0,     32'h0000_0000, 1'b0, 1};
        vecs[1] = '{1'b1, 11'h000, 32'h0000_0000, 32'h0000_0001, 0,     32'h0000_0001, 1'b0, 1};
        vecs[2] = '{1'b1, 11'h7FF, 32'h1111_2222, 32'hA5A5_5A5A, 3,     32'hA5A5_5A5A, 1'b0, 4};
        vecs[3] = '{1'b0, 11'h123, 32'hFFFF_FFFF, 32'h7777_7777, 2,     32'h0000_0000, 1'b0, 3};
        vecs[4] = '{1'b1, 11'h055, 32'h0000_0000, 32'hCAFE_F00D, NEVER, 32'h0000_0000, 1'b1, 16};
        vecs[5] = '{1'b1, 11'h2AA, 32'h0000_0000, 32'h1234_5678, 15,    32'h1234_5678, 1'b0, 16};
        vecs[6] = '{1'b0, 11'h001, 32'h0BAD_0BAD, 32'h0000_0000, NEVER, 32'h0000_0000, 1'b1, 16};
        vecs[7] = '{1'b1, 11'h400, 32'h0000_0000, 32'h8000_0001, 14,    32'h8000_0001, 1'b0, 15};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;

        chk("rst_req_ready", 64'(req_ready_o), 64'd1);
        chk("rst_cfg_valid", 64'(cfg_valid_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_cfg_addr",  64'(cfg_addr_o),  64'd0);
        chk("rst_cfg_data",  64'(cfg_data_o),  64'd0);
        chk("rst_rsp_err",   64'(rsp_err_o),   64'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn(i, vecs[i]);
        end

        // Latency with always-ready slave and consumer, back-to-back requests
        cfg_ready_i = 1'b1;
        cfg_data_i  = 32'h0000_00AB;
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        req_rwn_i   = 1'b1;
        req_addr_i  = 11'h010;
        req_wdata_i = '0;
        @(negedge clk);                       // accepted at cycle N
        chk("lat_cfg_valid_n1", 64'(cfg_valid_o), 64'd1);
        chk("lat_rsp_valid_n1", 64'(rsp_valid_o), 64'd0);
        req_addr_i = 11'h020;
        @(negedge clk);
        chk("lat_rsp_valid_n2", 64'(rsp_valid_o), 64'd1);
        chk("lat_cfg_valid_n2", 64'(cfg_valid_o), 64'd0);
        chk("lat_rdata_n2",     64'(rsp_rdata_o), 64'h0000_00AB);
        @(negedge clk);
        chk("lat_req_ready_n3", 64'(req_ready_o), 64'd1);
        @(negedge clk);
        chk("lat_second_valid", 64'(cfg_valid_o), 64'd1);
        chk("lat_second_addr",  64'(cfg_addr_o),  64'h020);
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("lat_second_rsp", 64'(rsp_valid_o), 64'd1);
        @(negedge clk);
        cfg_ready_i = 1'b0;
        rsp_ready_i = 1'b0;
        chk("lat_back_idle", 64'(req_ready_o), 64'd1);

        // Response backpressure: outputs hold, new request waits
        req_valid_i = 1'b1;
        req_rwn_i   = 1'b1;
        req_addr_i  = 11'h0F0;
        @(negedge clk);
        cfg_ready_i = 1'b1;
        cfg_data_i  = 32'h5555_AAAA;
        req_addr_i  = 11'h0F1;
        @(negedge clk);
        cfg_ready_i = 1'b0;
        cfg_data_i  = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_rsp_valid", k), 64'(rsp_valid_o), 64'd1);
            chk($sformatf("bp%0d_rdata", k),     64'(rsp_rdata_o), 64'h5555_AAAA);
            chk($sformatf("bp%0d_err", k),       64'(rsp_err_o),   64'd0);
            chk($sformatf("bp%0d_req_ready", k), 64'(req_ready_o), 64'd0);
            chk($sformatf("bp%0d_cfg_valid", k), 64'(cfg_valid_o), 64'd0);
            @(negedge clk);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk("bp_idle_req_ready", 64'(req_ready_o), 64'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("bp_next_cfg_valid", 64'(cfg_valid_o), 64'd1);
        chk("bp_next_addr",      64'(cfg_addr_o),  64'h0F1);

        // Reset in the middle of that access: no response follows
        repeat (3) @(negedge clk);
        chk("mid_still_access", 64'(cfg_valid_o), 64'd1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("mrst_cfg_valid", 64'(cfg_valid_o), 64'd0);
        chk("mrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("mrst_req_ready", 64'(req_ready_o), 64'd1);
        chk("mrst_cfg_addr",  64'(cfg_addr_o),  64'd0);
        repeat (20) begin
            @(negedge clk);
            chk("mrst_no_rsp", 64'(rsp_valid_o), 64'd0);
        end

        // A timeout followed by a clean read clears the error flag
        run_txn(8, vecs[4]);
        run_txn(9, vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
